// File: rtl/stream_packer.sv
// stream_packer: packs a narrow symbol stream into wide words, first symbol
// in the MSBs. A packet ending mid-word is flushed left-aligned and
// zero-padded, with out_count giving the number of valid symbols.
//
// Handshake (both ports): a transfer happens on a rising clk edge where
// valid & ready are both 1. Once out_valid is raised, out_data/out_last/
// out_count hold stable until out_ready is seen. in_ready depends only on
// rst, out_valid and out_ready, never on in_valid/in_data/in_last.
module stream_packer #(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 8,
  localparam int RATIO    = OUT_WIDTH / IN_WIDTH,
  localparam int CNT_W    = $clog2(RATIO + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [CNT_W-1:0]     out_count,
  input  logic                 out_ready
);

  // Reject geometries that cannot pack whole symbols into at least two slots.
  if ((OUT_WIDTH % IN_WIDTH) != 0 || (OUT_WIDTH / IN_WIDTH) < 2) begin : g_bad_params
    $error("stream_packer: OUT_WIDTH must be a multiple of IN_WIDTH with ratio >= 2");
  end

  localparam int PAD_W = OUT_WIDTH - IN_WIDTH;

  logic [OUT_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;

  logic                 accept;
  logic                 word_done;
  logic                 out_taken;
  logic [OUT_WIDTH-1:0] sym_slot;
  logic [OUT_WIDTH-1:0] acc_merged;

  // Ready is freed either by an empty output register or by the downstream
  // taking the pending word this very cycle (allows bubble-free reload).
  always_comb begin
    in_ready  = ~rst & (~out_valid | out_ready);
    accept    = in_valid & in_ready;
    out_taken = out_valid & out_ready;
    word_done = (cnt == CNT_W'(RATIO - 1)) | in_last;
  end

  // Place the incoming symbol in slot cnt, counted from the MSB end. Slots at
  // and below cnt are always zero in acc, so OR-ing is a plain insert and the
  // unfilled lower slots of a flushed partial word come out zero.
  always_comb begin
    sym_slot   = {in_data, {PAD_W{1'b0}}} >> (32'(cnt) * IN_WIDTH);
    acc_merged = acc | sym_slot;
  end

  // Accumulator, slot counter and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_count <= '0;
    end else begin
      // Pending word leaves; a completing symbol below may reload it at once.
      if (out_taken) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (word_done) begin
          out_data  <= acc_merged;
          out_count <= cnt + CNT_W'(1);
          out_last  <= in_last;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_merged;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Testbench for stream_packer (IN_WIDTH=2, OUT_WIDTH=8): table of per-cycle
// vectors with hand-computed expectations, then a back-to-back random run
// checked against a scoreboard of reference-packed words.
module tb_stream_packer;

  localparam int IW = 2;
  localparam int OW = 8;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] out_count;
  logic          out_ready;

  int checks;
  int errors;

  stream_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector = inputs applied for one cycle plus the outputs expected in
  // that same cycle (registered outputs from earlier edges, in_ready live).
  typedef struct {
    logic          rst;
    logic          in_valid;
    logic [IW-1:0] in_data;
    logic          in_last;
    logic          out_ready;
    logic          exp_in_ready;
    logic          exp_out_valid;
    logic          chk_data;
    logic [OW-1:0] exp_data;
    logic          exp_last;
    logic [CW-1:0] exp_count;
  } vec_t;

  vec_t vecs[$];
  logic [OW-1:0] exp_q[$];

  function automatic void add(input logic r, input logic iv, input logic [IW-1:0] d,
                              input logic l, input logic ordy, input logic eir,
                              input logic eov, input logic chk, input logic [OW-1:0] ed,
                              input logic el, input logic [CW-1:0] ec);
    vec_t v;
    v.rst = r; v.in_valid = iv; v.in_data = d; v.in_last = l; v.out_ready = ordy;
    v.exp_in_ready = eir; v.exp_out_valid = eov; v.chk_data = chk;
    v.exp_data = ed; v.exp_last = el; v.exp_count = ec;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Driver task: apply inputs away from the rising edge.
  task automatic drive(input logic r, input logic iv, input logic [IW-1:0] d,
                       input logic l, input logic ordy);
    rst = r; in_valid = iv; in_data = d; in_last = l; out_ready = ordy;
  endtask

  initial begin
    logic [OW-1:0] word;
    logic [IW-1:0] sym;
    int words_seen;

    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);

    //   rst iv data  last ordy | ir ov chk data  last cnt
    // reset values
    add(1, 0, 2'b00, 0, 1,   0, 0, 1, 8'h00, 0, 0);
    // full word 11 00 10 01 -> C9
    add(0, 1, 2'b11, 0, 1,   1, 0, 1, 8'h00, 0, 0);
    add(0, 1, 2'b00, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b10, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b01, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 2'b00, 0, 1,   1, 1, 1, 8'hC9, 0, 4);
    add(0, 0, 2'b00, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    // partial flush 01 10 11(last) -> 6C, count 3
    add(0, 1, 2'b01, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b10, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b11, 1, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 2'b00, 0, 1,   1, 1, 1, 8'h6C, 1, 3);
    // single-symbol packet 10 -> 80, starts again at MSB slot
    add(0, 1, 2'b10, 1, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 2'b00, 0, 1,   1, 1, 1, 8'h80, 1, 1);
    // full word with last on 4th: 01 01 01 11 -> 57, count 4, no extra word
    add(0, 1, 2'b01, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b01, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b01, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b11, 1, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 2'b00, 0, 1,   1, 1, 1, 8'h57, 1, 4);
    add(0, 0, 2'b00, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 2'b00, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    // backpressure: word F0 held 5 cycles, symbol 10 waits
    add(0, 1, 2'b11, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b11, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b00, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b00, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 2'b10, 0, 0, 0, 1, 1, 8'hF0, 0, 4);
    add(0, 1, 2'b10, 0, 1,   1, 1, 1, 8'hF0, 0, 4);
    add(0, 0, 2'b00, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    // held-back symbol 10 then 01(last) -> 90, count 2
    add(0, 1, 2'b01, 1, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 2'b00, 0, 0,   0, 1, 1, 8'h90, 1, 2);
    add(0, 0, 2'b00, 0, 1,   1, 1, 1, 8'h90, 1, 2);
    add(0, 0, 2'b00, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    // consume and complete in the same cycle: C0 then 40 with no bubble
    add(0, 1, 2'b11, 1, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b01, 1, 1,   1, 1, 1, 8'hC0, 1, 1);
    add(0, 0, 2'b00, 0, 1,   1, 1, 1, 8'h40, 1, 1);
    add(0, 0, 2'b00, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    // reset mid-word: partial 11 11 discarded; 00 01 10 11 -> 1B
    add(0, 1, 2'b11, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b11, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(1, 1, 2'b11, 0, 1,   0, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b00, 0, 1,   1, 0, 1, 8'h00, 0, 0);
    add(0, 1, 2'b01, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b10, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 2'b11, 0, 1,   1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 2'b00, 0, 1,   1, 1, 1, 8'h1B, 0, 4);
    add(0, 0, 2'b00, 0, 1,   1, 0, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].in_valid, vecs[i].in_data, vecs[i].in_last,
            vecs[i].out_ready);
      #1;
      check("in_ready", i, 32'(in_ready), 32'(vecs[i].exp_in_ready));
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_out_valid));
      if (vecs[i].chk_data) begin
        check("out_data", i, 32'(out_data), 32'(vecs[i].exp_data));
        check("out_last", i, 32'(out_last), 32'(vecs[i].exp_last));
        check("out_count", i, 32'(out_count), 32'(vecs[i].exp_count));
      end
    end

    // Back-to-back: 64 random symbols, one per cycle, 16 words expected.
    word = '0;
    words_seen = 0;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      if (i < 64) begin
        sym = IW'($urandom_range(0, 3));
        drive(1'b0, 1'b1, sym, 1'b0, 1'b1);
        word = {word[OW-IW-1:0], sym};
        if ((i % 4) == 3) exp_q.push_back(word);
      end else begin
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      end
      #1;
      if (i < 64) check("b2b_in_ready", i, 32'(in_ready), 32'd1);
      if (out_valid) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_word", i, 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("b2b_data", i, 32'(out_data), 32'(exp_q.pop_front()));
          check("b2b_count", i, 32'(out_count), 32'd4);
          check("b2b_last", i, 32'(out_last), 32'd0);
        end
      end
    end
    check("b2b_words", 0, 32'(words_seen), 32'd16);
    check("b2b_queue_left", 0, 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
